// File: rtl/dmem_access_unit_if.sv
// -----------------------------------------------------------------------------
// dmem_access_unit_if
// Valid/ready data-bus bundle between the memory-stage access unit (master)
// and the data memory or interconnect (slave).
//
// Signals:
//   req_valid  master->slave  request valid, held with stable fields until accepted
//   req_ready  slave->master  request accepted this cycle
//   addr       master->slave  word-aligned byte address (low 2 bits always 0)
//   we         master->slave  1 = write, 0 = read
//   wstrb      master->slave  byte-lane write strobes
//   wdata      master->slave  lane-aligned write data
//   rsp_valid  slave->master  one-cycle response pulse (read data or write ack)
//   rsp_rdata  slave->master  read word, qualified by rsp_valid
//   err        master->slave  timeout abort pulse
// -----------------------------------------------------------------------------
interface dmem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [3:0]        wstrb;
   logic [31:0]       wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              err;

   modport master (
      output req_valid, addr, we, wstrb, wdata, err,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, addr, we, wstrb, wdata, err,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/dmem_access_unit.sv
// -----------------------------------------------------------------------------
// dmem_access_unit
// Memory-stage load/store unit. Takes the EX/MEM register outputs, issues one
// bus transaction per load/store, stalls the pipeline until it completes,
// formats store data/strobes and sign/zero-extends load data for MEM/WB.
// Misaligned or illegal-size accesses are flagged and never issued.
//
// Optional feature: define DMEM_TIMEOUT_EN to abort a response wait after
// TIMEOUT_CYCLES WAIT cycles (bus.err pulses in the resulting DONE cycle).
// Without it, WAIT lasts until the response arrives and bus.err is tied 0.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   ALUResult_m  byte address
//   WD_m         store data, value in the low bits
//   MemRead_m    load in MEM stage
//   WE_m         store in MEM stage (wins if MemRead_m is also set)
//   funct3_m     size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   ReadData_m   extended load result, non-zero only in DONE
//   stall_m      hold IF/ID/EX/MEM registers
//   misalign_m   combinational misaligned/illegal access flag
//   bus          master side of the data bus
// -----------------------------------------------------------------------------
module dmem_access_unit #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         ALUResult_m,
   input  logic [31:0]         WD_m,
   input  logic                MemRead_m,
   input  logic                WE_m,
   input  logic [2:0]          funct3_m,
   output logic [31:0]         ReadData_m,
   output logic                stall_m,
   output logic                misalign_m,
   dmem_access_unit_if.master  bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t            state, state_nx;
   logic              enable, access, illegal;
   logic [1:0]        size, off;
   logic [ADDR_W-1:0] addr_ext;
   logic [3:0]        wstrb_fmt;
   logic [31:0]       wdata_fmt;
   logic              timeout_hit;

   // Request fields captured at IDLE->REQ so the bus sees stable values even
   // if the pipeline inputs wiggle while the request is pending.
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [3:0]        wstrb_q;
   logic [31:0]       wdata_q;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic [31:0]       rdata_q;

   assign enable   = MemRead_m | WE_m;
   assign size     = funct3_m[1:0];
   assign off      = ALUResult_m[1:0];
   assign addr_ext = ADDR_W'(ALUResult_m);
   // 011, 110 and 111 have no load/store meaning; reject them like misalignment.
   assign illegal  = (funct3_m == 3'b011) | (funct3_m[2:1] == 2'b11);

   assign misalign_m = enable & (illegal
                                 | ((size == 2'b01) & off[0])
                                 | ((size == 2'b10) & (off != 2'b00)));
   assign access     = enable & ~misalign_m;
   assign stall_m    = access & (state != DONE);

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      wstrb_fmt = 4'b0000;
      wdata_fmt = '0;
      if (WE_m) begin
         unique case (size)
            2'b00:   begin wstrb_fmt = 4'b0001 << off; wdata_fmt = {4{WD_m[7:0]}};  end
            2'b01:   begin wstrb_fmt = 4'b0011 << off; wdata_fmt = {2{WD_m[15:0]}}; end
            default: begin wstrb_fmt = 4'b1111;        wdata_fmt = WD_m;            end
         endcase
      end
   end

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a response in that same cycle wins.
   assign timeout_hit = (state == WAIT) & ~bus.rsp_valid
                        & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
   assign bus.err     = err_q;
`else
   assign timeout_hit = 1'b0;
   assign bus.err     = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (access)        state_nx = REQ;
         REQ:  if (bus.req_ready) state_nx = WAIT;
         WAIT: if (bus.rsp_valid || timeout_hit) state_nx = DONE;
         DONE:                    state_nx = IDLE;
         default:                 state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wstrb_q <= 4'b0000;
         wdata_q <= '0;
         off_q   <= 2'b00;
         f3_q    <= 3'b000;
         rdata_q <= '0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (state == IDLE && access) begin
            addr_q  <= {addr_ext[ADDR_W-1:2], 2'b00};
            we_q    <= WE_m;
            wstrb_q <= wstrb_fmt;
            wdata_q <= wdata_fmt;
            off_q   <= off;
            f3_q    <= funct3_m;
         end
         // Responses outside WAIT (late, or after a reset) are dropped here.
         if (state == WAIT && bus.rsp_valid) rdata_q <= bus.rsp_rdata;
`ifdef DMEM_TIMEOUT_EN
         if (state == REQ && bus.req_ready) cnt_q <= '0;
         else if (state == WAIT)            cnt_q <= cnt_q + CNT_W'(1);
         if (timeout_hit) rdata_q <= '0;
         err_q <= timeout_hit;
`endif
      end
   end

   assign bus.req_valid = (state == REQ);
   assign bus.addr      = addr_q;
   assign bus.we        = we_q;
   assign bus.wstrb     = wstrb_q;
   assign bus.wdata     = wdata_q;

   always_comb begin
      ReadData_m = '0;
      if (state == DONE && !we_q) begin
         unique case (f3_q)
            3'b000:  ReadData_m = {{24{rdata_q[{off_q, 3'b000} + 7]}}, rdata_q[{off_q, 3'b000} +: 8]};
            3'b100:  ReadData_m = {24'h0, rdata_q[{off_q, 3'b000} +: 8]};
            3'b001:  ReadData_m = {{16{rdata_q[{off_q[1], 4'b0000} + 15]}}, rdata_q[{off_q[1], 4'b0000} +: 16]};
            3'b101:  ReadData_m = {16'h0, rdata_q[{off_q[1], 4'b0000} +: 16]};
            3'b010:  ReadData_m = rdata_q;
            default: ReadData_m = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_unit
// Self-checking bench for dmem_access_unit: directed vector table, randomized
// accesses against an arithmetic reference model, and hand-written reset and
// (with DMEM_TIMEOUT_EN) timeout sequences. Inputs change and outputs are
// sampled around the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_access_unit;
   localparam int ADDR_W = 32;
`ifdef DMEM_TIMEOUT_EN
   localparam int TMO = 4;
`else
   localparam int TMO = 64;
`endif
   localparam int MAX_WL = (TMO <= 6) ? TMO - 1 : 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUResult_m, WD_m, ReadData_m;
   logic        MemRead_m, WE_m, stall_m, misalign_m;
   logic [2:0]  funct3_m;

   dmem_access_unit_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset),
      .ALUResult_m(ALUResult_m), .WD_m(WD_m),
      .MemRead_m(MemRead_m), .WE_m(WE_m), .funct3_m(funct3_m),
      .ReadData_m(ReadData_m), .stall_m(stall_m), .misalign_m(misalign_m),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   typedef struct {
      logic [31:0] addr, wd;
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] rdata;
      logic        e_mis;
      logic [31:0] e_addr;
      logic [3:0]  e_strb;
      logic [31:0] e_wdata;
      logic        e_we;
      logic [31:0] e_read;
   } vec_t;

   function automatic vec_t mkv(logic [31:0] addr, wd, logic rd, wr, logic [2:0] f3,
                                logic [31:0] rdata, logic e_mis, logic [31:0] e_addr,
                                logic [3:0] e_strb, logic [31:0] e_wdata, logic e_we,
                                logic [31:0] e_read);
      vec_t v;
      v.addr = addr; v.wd = wd; v.rd = rd; v.wr = wr; v.f3 = f3; v.rdata = rdata;
      v.e_mis = e_mis; v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata;
      v.e_we = e_we; v.e_read = e_read;
      return v;
   endfunction

   // ---------------- reference model (plain arithmetic) ----------------
   function automatic int nbytes(logic [2:0] f3);
      return 1 << f3[1:0];
   endfunction

   function automatic logic model_mis(logic [31:0] a, logic rd, logic wr, logic [2:0] f3);
      if (!(rd || wr)) return 1'b0;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      return (a % nbytes(f3)) != 0;
   endfunction

   function automatic vec_t model(logic [31:0] a, wd, logic rd, wr, logic [2:0] f3, logic [31:0] rdata);
      vec_t v;
      int n;
      longint val, off;
      n = nbytes(f3);
      off = a % 4;
      v = mkv(a, wd, rd, wr, f3, rdata, model_mis(a, rd, wr, f3), a - off, 4'h0, 32'h0, wr, 32'h0);
      if (wr) begin
         v.e_strb  = 4'(((1 << n) - 1) << off);
         if (n == 1)      v.e_wdata = (wd % 256) * 32'h01010101;
         else if (n == 2) v.e_wdata = (wd % 65536) * 32'h00010001;
         else             v.e_wdata = wd;
      end else if (n == 4) begin
         v.e_read = rdata;
      end else begin
         val = (longint'(rdata) >> ((n == 2) ? (off / 2) * 16 : off * 8)) % (longint'(1) << (8 * n));
         if (!f3[2] && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
         v.e_read = 32'(val);
      end
      return v;
   endfunction

   // ---------------- access driver / checker ----------------
   // Fixed timeline: 1 IDLE cycle, rl+1 REQ cycles, wl+1 WAIT cycles, 1 DONE.
   task automatic run_access(input vec_t v, input int rl, input int wl, input string tag);
      @(negedge clk);
      ALUResult_m = v.addr; WD_m = v.wd; MemRead_m = v.rd; WE_m = v.wr; funct3_m = v.f3;
      bus.req_ready = 1'b0; bus.rsp_valid = 1'b0;
      #1;
      check({tag, " misalign"}, 32'(misalign_m), 32'(v.e_mis));
      if (v.e_mis || !(v.rd || v.wr)) begin
         for (int k = 0; k < 2; k++) begin
            check({tag, " noacc stall"}, 32'(stall_m), 32'h0);
            check({tag, " noacc req_valid"}, 32'(bus.req_valid), 32'h0);
            check({tag, " noacc rdata"}, ReadData_m, 32'h0);
            @(negedge clk); #1;
         end
         return;
      end
      check({tag, " idle stall"}, 32'(stall_m), 32'h1);
      check({tag, " idle req_valid"}, 32'(bus.req_valid), 32'h0);
      for (int k = 0; k <= rl; k++) begin
         @(negedge clk);
         bus.req_ready = (k == rl);
         #1;
         check({tag, " req_valid"}, 32'(bus.req_valid), 32'h1);
         check({tag, " req stall"}, 32'(stall_m), 32'h1);
         check({tag, " addr"}, bus.addr, v.e_addr);
         check({tag, " we"}, 32'(bus.we), 32'(v.e_we));
         check({tag, " wstrb"}, 32'(bus.wstrb), 32'(v.e_strb));
         if (v.wr) check({tag, " wdata"}, bus.wdata, v.e_wdata);
      end
      for (int k = 0; k <= wl; k++) begin
         @(negedge clk);
         bus.req_ready = 1'b0;
         bus.rsp_valid = (k == wl);
         bus.rsp_rdata = (k == wl) ? v.rdata : $urandom;
         #1;
         check({tag, " wait req_valid"}, 32'(bus.req_valid), 32'h0);
         check({tag, " wait stall"}, 32'(stall_m), 32'h1);
         check({tag, " wait rdata"}, ReadData_m, 32'h0);
      end
      @(negedge clk);
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = $urandom;
      #1;
      check({tag, " done stall"}, 32'(stall_m), 32'h0);
      check({tag, " done ReadData"}, ReadData_m, v.e_read);
      check({tag, " done err"}, 32'(bus.err), 32'h0);
   endtask

   task automatic go_idle();
      @(negedge clk);
      MemRead_m = 1'b0; WE_m = 1'b0;
      bus.req_ready = 1'b0; bus.rsp_valid = 1'b0;
      #1;
   endtask

   vec_t tbl[$];
   vec_t rv;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      ALUResult_m = '0; WD_m = '0; MemRead_m = 1'b0; WE_m = 1'b0; funct3_m = 3'b000;
      bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b0; #1;
      check("rst req_valid", 32'(bus.req_valid), 32'h0);
      check("rst stall", 32'(stall_m), 32'h0);
      check("rst misalign", 32'(misalign_m), 32'h0);
      check("rst ReadData", ReadData_m, 32'h0);
      check("rst err", 32'(bus.err), 32'h0);
      check("rst addr", bus.addr, 32'h0);
      check("rst we", 32'(bus.we), 32'h0);
      check("rst wstrb", 32'(bus.wstrb), 32'h0);
      check("rst wdata", bus.wdata, 32'h0);

      //          addr          wd            rd wr f3      rdata         mis e_addr        strb     e_wdata       we e_read
      tbl.push_back(mkv(32'h100, 32'h0,       1, 0, 3'b010, 32'hDEADBEEF, 0, 32'h100, 4'b0000, 32'h0,        0, 32'hDEADBEEF));
      tbl.push_back(mkv(32'h203, 32'h000000A5, 0, 1, 3'b000, 32'h0,       0, 32'h200, 4'b1000, 32'hA5A5A5A5, 1, 32'h0));
      tbl.push_back(mkv(32'h102, 32'h0,       1, 0, 3'b000, 32'h00F30000, 0, 32'h100, 4'b0000, 32'h0,        0, 32'hFFFFFFF3));
      tbl.push_back(mkv(32'h102, 32'h0,       1, 0, 3'b100, 32'h00F30000, 0, 32'h100, 4'b0000, 32'h0,        0, 32'h000000F3));
      tbl.push_back(mkv(32'h102, 32'h0,       1, 0, 3'b001, 32'h80010000, 0, 32'h100, 4'b0000, 32'h0,        0, 32'hFFFF8001));
      tbl.push_back(mkv(32'h101, 32'h0,       1, 0, 3'b010, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0, 32'h0));
      tbl.push_back(mkv(32'h102, 32'h1234ABCD, 0, 1, 3'b001, 32'h0,       0, 32'h100, 4'b1100, 32'hABCDABCD, 1, 32'h0));
      tbl.push_back(mkv(32'h300, 32'h11223344, 0, 1, 3'b010, 32'h0,       0, 32'h300, 4'b1111, 32'h11223344, 1, 32'h0));
      tbl.push_back(mkv(32'h100, 32'h0,       1, 0, 3'b101, 32'h1234F00D, 0, 32'h100, 4'b0000, 32'h0,        0, 32'h0000F00D));
      tbl.push_back(mkv(32'h103, 32'h0,       1, 0, 3'b000, 32'h80000000, 0, 32'h100, 4'b0000, 32'h0,        0, 32'hFFFFFF80));
      tbl.push_back(mkv(32'h000, 32'h0,       1, 0, 3'b011, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0, 32'h0));
      tbl.push_back(mkv(32'h201, 32'h5555,    0, 1, 3'b001, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0, 32'h0));
      tbl.push_back(mkv(32'h010, 32'hCAFEF00D, 1, 1, 3'b010, 32'h12345678, 0, 32'h010, 4'b1111, 32'hCAFEF00D, 1, 32'h0));
      tbl.push_back(mkv(32'h040, 32'h0,       0, 1, 3'b110, 32'h0,        1, 32'h0,   4'b0000, 32'h0,        0, 32'h0));
      tbl.push_back(mkv(32'h001, 32'h000000C3, 0, 1, 3'b000, 32'h0,       0, 32'h000, 4'b0010, 32'hC3C3C3C3, 1, 32'h0));

      // Back-to-back: each vector enters the cycle after the previous DONE.
      foreach (tbl[i]) run_access(tbl[i], 0, 0, $sformatf("vec%0d", i));
      go_idle();

      // Request held 5 cycles with ready low: fields must stay stable.
      run_access(tbl[7], 5, 0, "hold_ready");
      run_access(tbl[0], 2, MAX_WL, "slow_rsp");
      go_idle();

      // Reset in WAIT; a late response must not surface.
      @(negedge clk); ALUResult_m = 32'h40; MemRead_m = 1'b1; WE_m = 1'b0; funct3_m = 3'b010;
      @(negedge clk); bus.req_ready = 1'b1;
      @(negedge clk); bus.req_ready = 1'b0; reset = 1'b1; MemRead_m = 1'b0; #1;
      check("wait_rst stall_before", 32'(stall_m), 32'h0);
      @(negedge clk); reset = 1'b0; #1;
      check("wait_rst req_valid", 32'(bus.req_valid), 32'h0);
      @(negedge clk); bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hFFFF1234; #1;
      check("wait_rst late rsp ReadData", ReadData_m, 32'h0);
      @(negedge clk); bus.rsp_valid = 1'b0; #1;
      check("wait_rst after rsp ReadData", ReadData_m, 32'h0);
      check("wait_rst after rsp req_valid", 32'(bus.req_valid), 32'h0);
      run_access(tbl[2], 0, 0, "post_wait_rst");
      go_idle();

      // Reset in REQ: request must drop the next cycle.
      @(negedge clk); ALUResult_m = 32'h80; MemRead_m = 1'b0; WE_m = 1'b1; WD_m = 32'h77; funct3_m = 3'b000;
      @(negedge clk); #1;
      check("req_rst req_valid_before", 32'(bus.req_valid), 32'h1);
      reset = 1'b1; WE_m = 1'b0;
      @(negedge clk); reset = 1'b0; #1;
      check("req_rst req_valid_after", 32'(bus.req_valid), 32'h0);
      @(negedge clk); #1;
      check("req_rst req_valid_later", 32'(bus.req_valid), 32'h0);

`ifdef DMEM_TIMEOUT_EN
      // No response: DONE after TMO WAIT cycles with a one-cycle err pulse.
      @(negedge clk); ALUResult_m = 32'h80; MemRead_m = 1'b1; funct3_m = 3'b010; #1;
      check("tmo idle stall", 32'(stall_m), 32'h1);
      @(negedge clk); bus.req_ready = 1'b1; #1;
      check("tmo req_valid", 32'(bus.req_valid), 32'h1);
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk); bus.req_ready = 1'b0; #1;
         check("tmo wait stall", 32'(stall_m), 32'h1);
         check("tmo wait err", 32'(bus.err), 32'h0);
      end
      @(negedge clk); #1;
      check("tmo done stall", 32'(stall_m), 32'h0);
      check("tmo done err", 32'(bus.err), 32'h1);
      check("tmo done ReadData", ReadData_m, 32'h0);
      go_idle();
      check("tmo err cleared", 32'(bus.err), 32'h0);
      check("tmo idle stall_after", 32'(stall_m), 32'h0);
`else
      run_access(tbl[0], 0, 20, "long_wait");
      go_idle();
`endif

      // Randomized accesses against the reference model.
      for (int i = 0; i < 60; i++) begin
         logic rd, wr;
         rd = 1'($urandom);
         wr = 1'($urandom);
         if (i % 10 == 9) begin rd = 1'b0; wr = 1'b0; end
         rv = model($urandom, $urandom, rd, wr, 3'($urandom_range(0, 7)), $urandom);
         run_access(rv, $urandom_range(0, 3), $urandom_range(0, MAX_WL), $sformatf("rnd%0d", i));
         if ($urandom_range(0, 3) == 0) go_idle();
      end
      go_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
